// File: rtl/mac_pkg.sv
// Shared definitions for the receive MAC framer: FSM states, framing bytes and CRC constants.
package mac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        DEST,
        SOURCE,
        TYPE,
        PAYLOAD,
        DROP,
        DONE
    } mac_rx_state;

    localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
    localparam logic [7:0]  SFD_BYTE       = 8'hD5;
    localparam logic [47:0] BROADCAST_ADDR = 48'hFFFF_FFFF_FFFF;
    localparam logic [31:0] CRC_INIT       = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE    = 32'hC704_DD7B;
    localparam int          FCS_BYTES      = 4;

endpackage

// File: rtl/crc32.sv
// Combinational Ethernet CRC-32 step: folds WIDTH bits (LSB first, wire order) into crc_in.
// Non-reflected register form, so a frame with a good FCS leaves residue 32'hC704DD7B.
module crc32 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] din,
    input  logic [31:0]      crc_in,
    output logic [31:0]      crc_out
);

    localparam logic [31:0] POLY = 32'h04C1_1DB7;

    logic [31:0] c;
    logic        fb;

    always_comb begin
        c  = crc_in;
        fb = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            fb = c[31] ^ din[i];
            c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
        end
        crc_out = c;
    end

endmodule

// File: rtl/mac_rx_delay_line.sv
// FCS_BYTES-deep byte shift register; dout is the oldest byte, valid once the line has filled.
module mac_rx_delay_line
    import mac_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       shift_en,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full
);

    logic [7:0]           data [FCS_BYTES];
    logic [FCS_BYTES-1:0] vld;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            vld <= '0;
        end else if (shift_en) begin
            vld <= {vld[FCS_BYTES-2:0], 1'b1};
        end
    end

    // Data needs no reset: it is only observed once vld marks it as filled.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            data[0] <= din;
            for (int i = 1; i < FCS_BYTES; i++) begin
                data[i] <= data[i-1];
            end
        end
    end

    assign dout = data[FCS_BYTES-1];
    assign full = vld[FCS_BYTES-1];

endmodule

// File: rtl/mac_decode.sv
// Receive-side MAC framer: preamble/SFD strip, destination filter, header extract, FCS check.
// Define MAC_DECODE_PROMISC_EN to accept every frame regardless of destination address.
module mac_decode
    import mac_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR  = 48'h0,
    parameter logic [15:0] MIN_FRAME = 16'd64,
    parameter logic [15:0] MAX_FRAME = 16'd1518
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mac_phy_rxdv,
    input  logic        mac_phy_rxer,
    input  logic [7:0]  mac_phy_rxd,
    output logic        hdr_valid,
    output logic [47:0] mac_src,
    output logic [15:0] ethertype,
    output logic        payload_valid,
    output logic [7:0]  payload_data,
    output logic        frame_done,
    output logic        frame_ok,
    output logic        frame_err_crc,
    output logic        frame_err_len
);

    mac_rx_state state;
    logic [31:0] crc_reg;
    logic [31:0] crc_out;
    logic [15:0] byte_cnt;
    logic [15:0] cnt_next;
    logic [2:0]  field_cnt;
    logic [47:0] dest_sr;
    logic [47:0] src_sr;
    logic [7:0]  type_hi;
    logic        rxer_seen;
    logic [47:0] dest_full;
    logic        dest_ok;
    logic        crc_bad;
    logic        len_bad;
    logic        dl_shift;
    logic        dl_clear;
    logic [7:0]  dl_out;
    logic        dl_full;

    crc32 #(.WIDTH(8)) u_crc (
        .din    (mac_phy_rxd),
        .crc_in (crc_reg),
        .crc_out(crc_out)
    );

    assign dl_shift = (state == PAYLOAD) && mac_phy_rxdv;
    assign dl_clear = (state != PAYLOAD);

    mac_rx_delay_line u_delay (
        .clk     (clk),
        .rst     (rst),
        .clear   (dl_clear),
        .shift_en(dl_shift),
        .din     (mac_phy_rxd),
        .dout    (dl_out),
        .full    (dl_full)
    );

    assign cnt_next  = (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;
    assign dest_full = {dest_sr[39:0], mac_phy_rxd};

`ifdef MAC_DECODE_PROMISC_EN
    assign dest_ok = 1'b1;
`else
    assign dest_ok = (dest_full == MAC_ADDR) || (dest_full == BROADCAST_ADDR);
`endif

    // Verdict terms, evaluated on the cycle rxdv is seen low inside a frame.
    assign crc_bad = (crc_reg != CRC_RESIDUE);
    assign len_bad = (byte_cnt < MIN_FRAME) || (byte_cnt > MAX_FRAME) || (state != PAYLOAD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            crc_reg       <= CRC_INIT;
            byte_cnt      <= '0;
            field_cnt     <= '0;
            dest_sr       <= '0;
            src_sr        <= '0;
            type_hi       <= '0;
            rxer_seen     <= 1'b0;
            hdr_valid     <= 1'b0;
            mac_src       <= '0;
            ethertype     <= '0;
            payload_valid <= 1'b0;
            payload_data  <= '0;
            frame_done    <= 1'b0;
            frame_ok      <= 1'b0;
            frame_err_crc <= 1'b0;
            frame_err_len <= 1'b0;
        end else begin
            hdr_valid     <= 1'b0;
            payload_valid <= 1'b0;
            frame_done    <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (mac_phy_rxdv) begin
                        state <= (mac_phy_rxd == PREAMBLE_BYTE) ? PREAMBLE : DROP;
                    end else begin
                        state <= IDLE;
                    end
                end
                PREAMBLE: begin
                    if (!mac_phy_rxdv) begin
                        state <= IDLE;
                    end else if (mac_phy_rxd == SFD_BYTE) begin
                        state     <= DEST;
                        crc_reg   <= CRC_INIT;
                        byte_cnt  <= '0;
                        field_cnt <= '0;
                        rxer_seen <= 1'b0;
                    end else if (mac_phy_rxd != PREAMBLE_BYTE) begin
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (!mac_phy_rxdv) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    if (!mac_phy_rxdv) begin
                        state         <= DONE;
                        frame_done    <= 1'b1;
                        frame_err_crc <= crc_bad;
                        frame_err_len <= len_bad;
                        frame_ok      <= ~(crc_bad | len_bad | rxer_seen);
                    end else begin
                        crc_reg  <= crc_out;
                        byte_cnt <= cnt_next;
                        if (mac_phy_rxer) begin
                            rxer_seen <= 1'b1;
                        end
                        case (state)
                            DEST: begin
                                dest_sr <= dest_full;
                                if (field_cnt == 3'd5) begin
                                    field_cnt <= '0;
                                    state     <= dest_ok ? SOURCE : DROP;
                                end else begin
                                    field_cnt <= field_cnt + 3'd1;
                                end
                            end
                            SOURCE: begin
                                src_sr <= {src_sr[39:0], mac_phy_rxd};
                                if (field_cnt == 3'd5) begin
                                    field_cnt <= '0;
                                    state     <= TYPE;
                                end else begin
                                    field_cnt <= field_cnt + 3'd1;
                                end
                            end
                            TYPE: begin
                                if (field_cnt == 3'd0) begin
                                    type_hi   <= mac_phy_rxd;
                                    field_cnt <= 3'd1;
                                end else begin
                                    field_cnt <= '0;
                                    hdr_valid <= 1'b1;
                                    mac_src   <= src_sr;
                                    ethertype <= {type_hi, mac_phy_rxd};
                                    state     <= PAYLOAD;
                                end
                            end
                            PAYLOAD: begin
                                // The four newest bytes stay held back; whatever is left at rxdv fall is the FCS.
                                if (dl_full && (cnt_next <= MAX_FRAME)) begin
                                    payload_valid <= 1'b1;
                                    payload_data  <= dl_out;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_decode.sv
// Directed bench for mac_decode with a queue-based scoreboard for header, payload and verdicts.
module tb_mac_decode;

    localparam logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_02;
    localparam logic [47:0] OTHER_MAC = 48'h02_00_00_00_00_01;
    localparam logic [47:0] BCAST     = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] SRC_A     = 48'h02_11_22_33_44_55;
    localparam logic [47:0] SRC_B     = 48'h0A_BC_DE_F0_12_34;

    logic        clk = 1'b0;
    logic        rst;
    logic        mac_phy_rxdv;
    logic        mac_phy_rxer;
    logic [7:0]  mac_phy_rxd;
    logic        hdr_valid;
    logic [47:0] mac_src;
    logic [15:0] ethertype;
    logic        payload_valid;
    logic [7:0]  payload_data;
    logic        frame_done;
    logic        frame_ok;
    logic        frame_err_crc;
    logic        frame_err_len;

    always #5 clk = ~clk;

    mac_decode #(
        .MAC_ADDR (LOCAL_MAC),
        .MIN_FRAME(16'd64),
        .MAX_FRAME(16'd1518)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mac_phy_rxdv (mac_phy_rxdv),
        .mac_phy_rxer (mac_phy_rxer),
        .mac_phy_rxd  (mac_phy_rxd),
        .hdr_valid    (hdr_valid),
        .mac_src      (mac_src),
        .ethertype    (ethertype),
        .payload_valid(payload_valid),
        .payload_data (payload_data),
        .frame_done   (frame_done),
        .frame_ok     (frame_ok),
        .frame_err_crc(frame_err_crc),
        .frame_err_len(frame_err_len)
    );

    int checks = 0;
    int errors = 0;
    int hdr_seen = 0;
    int pay_seen = 0;
    int done_seen = 0;

    logic [7:0]  frm[$];
    logic [7:0]  exp_pay_q[$];
    logic [63:0] exp_hdr_q[$];
    logic [2:0]  exp_done_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference Ethernet FCS: reflected CRC-32, final inversion, appended LSB first.
    task automatic append_fcs();
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (frm[i]) begin
            c = c ^ {24'h0, frm[i]};
            for (int b = 0; b < 8; b++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            end
        end
        c = ~c;
        for (int k = 0; k < 4; k++) begin
            frm.push_back(c[8*k +: 8]);
        end
    endtask

    task automatic build_frame(input logic [47:0] dst, input logic [47:0] src,
                               input logic [15:0] typ, input int plen, input logic [7:0] first);
        frm.delete();
        for (int i = 5; i >= 0; i--) frm.push_back(dst[8*i +: 8]);
        for (int i = 5; i >= 0; i--) frm.push_back(src[8*i +: 8]);
        frm.push_back(typ[15:8]);
        frm.push_back(typ[7:0]);
        for (int i = 0; i < plen; i++) frm.push_back(first + 8'(i));
        append_fcs();
    endtask

    task automatic expect_frame(input logic crc_bad, input logic rxer_hit);
        logic [63:0] h;
        logic        len_bad;
        h = '0;
        for (int i = 6; i < 14; i++) h = {h[55:0], frm[i]};
        exp_hdr_q.push_back(h);
        for (int i = 14; i < frm.size() - 4; i++) exp_pay_q.push_back(frm[i]);
        len_bad = (frm.size() < 64) || (frm.size() > 1518);
        exp_done_q.push_back({~(crc_bad | len_bad | rxer_hit), crc_bad, len_bad});
    endtask

    task automatic send_frame(input int count, input int rxer_at, input bit finish);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            mac_phy_rxdv = 1'b1;
            mac_phy_rxer = 1'b0;
            mac_phy_rxd  = (i == 7) ? 8'hD5 : 8'h55;
        end
        for (int i = 0; i < count; i++) begin
            @(negedge clk);
            mac_phy_rxd  = frm[i];
            mac_phy_rxer = (i == rxer_at);
        end
        if (finish) begin
            @(negedge clk);
            mac_phy_rxdv = 1'b0;
            mac_phy_rxer = 1'b0;
            mac_phy_rxd  = 8'h00;
        end
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_pay_q.size() + exp_hdr_q.size() + exp_done_q.size()) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(exp_pay_q.size() + exp_hdr_q.size() + exp_done_q.size()), 64'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_hdr_valid"}, 64'(hdr_valid), 64'd0);
        check({tag, "_mac_src"}, 64'(mac_src), 64'd0);
        check({tag, "_ethertype"}, 64'(ethertype), 64'd0);
        check({tag, "_payload_valid"}, 64'(payload_valid), 64'd0);
        check({tag, "_payload_data"}, 64'(payload_data), 64'd0);
        check({tag, "_frame_done"}, 64'(frame_done), 64'd0);
        check({tag, "_verdict"}, 64'({frame_ok, frame_err_crc, frame_err_len}), 64'd0);
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (hdr_valid === 1'b1) begin
                hdr_seen++;
                if (exp_hdr_q.size() == 0) check("hdr_unexpected", 64'(hdr_valid), 64'd0);
                else check("hdr", {mac_src, ethertype}, exp_hdr_q.pop_front());
            end
            if (payload_valid === 1'b1) begin
                pay_seen++;
                if (exp_pay_q.size() == 0) check("payload_unexpected", 64'(payload_valid), 64'd0);
                else check("payload", 64'(payload_data), 64'(exp_pay_q.pop_front()));
            end
            if (frame_done === 1'b1) begin
                done_seen++;
                if (exp_done_q.size() == 0) check("done_unexpected", 64'(frame_done), 64'd0);
                else check("verdict", 64'({frame_ok, frame_err_crc, frame_err_len}),
                           64'(exp_done_q.pop_front()));
            end
        end
    endtask

    initial begin
        int d0;
        int h0;
        int p0;
        rst          = 1'b1;
        mac_phy_rxdv = 1'b0;
        mac_phy_rxer = 1'b0;
        mac_phy_rxd  = 8'h00;
        repeat (4) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        fork
            monitor();
        join_none

        // Broadcast, 46-byte payload 00..2D, good FCS.
        build_frame(BCAST, SRC_A, 16'h0800, 46, 8'h00);
        expect_frame(1'b0, 1'b0);
        send_frame(frm.size(), -1, 1'b1);
        wait_drain("drain_good_bcast");

        // Same frame with the last FCS byte corrupted.
        build_frame(BCAST, SRC_A, 16'h0800, 46, 8'h00);
        frm[frm.size() - 1] = frm[frm.size() - 1] ^ 8'h01;
        expect_frame(1'b1, 1'b0);
        send_frame(frm.size(), -1, 1'b1);
        wait_drain("drain_bad_fcs");

        // Foreign unicast destination is dropped silently.
        d0 = done_seen;
        h0 = hdr_seen;
        p0 = pay_seen;
        build_frame(OTHER_MAC, SRC_B, 16'h0806, 46, 8'h40);
        send_frame(frm.size(), -1, 1'b1);
        repeat (10) @(negedge clk);
        check("filter_done", 64'(done_seen), 64'(d0));
        check("filter_hdr", 64'(hdr_seen), 64'(h0));
        check("filter_payload", 64'(pay_seen), 64'(p0));

        // 30-byte runt with a valid FCS.
        build_frame(BCAST, SRC_B, 16'h86DD, 12, 8'hA0);
        expect_frame(1'b0, 1'b0);
        send_frame(frm.size(), -1, 1'b1);
        wait_drain("drain_runt");

        // rxer on payload byte 10; data still streams.
        build_frame(LOCAL_MAC, SRC_A, 16'h0800, 46, 8'h10);
        expect_frame(1'b0, 1'b1);
        send_frame(frm.size(), 14 + 10, 1'b1);
        wait_drain("drain_rxer");

        // Reset while in SOURCE aborts the frame; the next one decodes normally.
        d0 = done_seen;
        build_frame(LOCAL_MAC, SRC_B, 16'h0800, 46, 8'h20);
        send_frame(9, -1, 1'b0);
        @(negedge clk);
        rst          = 1'b1;
        mac_phy_rxdv = 1'b0;
        mac_phy_rxd  = 8'h00;
        repeat (2) @(negedge clk);
        check_idle_outputs("midframe_reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_abort_done", 64'(done_seen), 64'(d0));
        build_frame(LOCAL_MAC, SRC_B, 16'h0800, 50, 8'h30);
        expect_frame(1'b0, 1'b0);
        send_frame(frm.size(), -1, 1'b1);
        wait_drain("drain_after_reset");

        // Back-to-back frames separated by a single idle cycle, random payload seeds.
        build_frame(BCAST, SRC_A, 16'h0800, 46, 8'($urandom_range(0, 255)));
        expect_frame(1'b0, 1'b0);
        send_frame(frm.size(), -1, 1'b1);
        build_frame(LOCAL_MAC, SRC_B, 16'h88B5, $urandom_range(46, 80), 8'($urandom_range(0, 255)));
        expect_frame(1'b0, 1'b0);
        send_frame(frm.size(), -1, 1'b1);
        wait_drain("drain_back_to_back");

        repeat (5) @(negedge clk);
        check("final_queues_empty", 64'(exp_pay_q.size() + exp_hdr_q.size() + exp_done_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
